if_id_buffer: RTL

Instruction-fetch to decode pipeline buffer for the RV32I core. Sits directly downstream of the fetch stage and captures each fetched instruction with its PC into a two-entry skid buffer. Presents one instruction per cycle to decode, absorbs decode stalls without losing in-flight fetch data, and discards buffered instructions on a control-flow redirect, inserting NOP bubbles.

---
 rtl/rv32i_pkg.sv | 13 +
 rtl/if_id_perf.sv | 40 ++++
 rtl/if_id_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: NOP encoding, default datapath width
// and the IF/ID slot bundle.
package rv32i_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
    } slot_t;

endpackage

// File: rtl/if_id_perf.sv
// IF/ID performance counters: decode-side bubbles and flush events.
// Only instantiated when IF_ID_PERF_EN is defined.
module if_id_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
);

    logic [31:0] bubble_q, bubble_d;
    logic [31:0] flush_q, flush_d;

    always_comb begin
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (!out_valid && !stall) begin
            bubble_d = bubble_q + 32'd1;
        end
        if (flush) begin
            flush_d = flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign bubble_count = bubble_q;
    assign flush_count  = flush_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID two-entry skid buffer with flush-to-NOP.
// Define IF_ID_PERF_EN to add bubble_count/flush_count outputs.
module if_id_buffer
    import rv32i_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_valid,
    input  logic [DataWidth-1:0] instruction_in,
    input  logic [DataWidth-1:0] pc_in,
    input  logic                 flush,
    input  logic                 stall,
    output logic                 ready_out,
    output logic                 out_valid,
    output logic [DataWidth-1:0] instruction_out,
    output logic [DataWidth-1:0] pc_out
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]          bubble_count,
    output logic [31:0]          flush_count
`endif
);

    localparam slot_t EMPTY_HEAD = '{instr: NOP_INSTR, pc: '0};
    localparam slot_t EMPTY_SKID = '0;

    logic [1:0] count_q, count_d;
    slot_t      head_q, head_d;
    slot_t      skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    slot_t      in_slot;
    logic       push;
    logic       pop;

    assign in_slot   = '{instr: instruction_in, pc: pc_in};
    assign ready_out = (count_q != 2'd2);
    assign push      = imem_valid && ready_out && !flush;
    assign pop       = out_valid_q && !stall;

    // Head always holds NOP/0 when empty so outputs need no extra muxing.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = EMPTY_HEAD;
            skid_d  = EMPTY_SKID;
        end else if (push && pop) begin
            head_d = in_slot;
        end else if (pop) begin
            if (count_q == 2'd2) begin
                head_d  = skid_q;
                skid_d  = EMPTY_SKID;
                count_d = 2'd1;
            end else begin
                head_d  = EMPTY_HEAD;
                count_d = 2'd0;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d  = in_slot;
                count_d = 2'd1;
            end else begin
                skid_d  = in_slot;
                count_d = 2'd2;
            end
        end
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= 2'd0;
            head_q      <= EMPTY_HEAD;
            skid_q      <= EMPTY_SKID;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign instruction_out = head_q.instr;
    assign pc_out          = head_q.pc;

`ifdef IF_ID_PERF_EN
    if_id_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .out_valid    (out_valid_q),
        .stall        (stall),
        .flush        (flush),
        .bubble_count (bubble_count),
        .flush_count  (flush_count)
    );
`endif

endmodule
